trig_info_recorder: RTL and testbench
=====================================

TRIG_INFO_RECORDER -- requirements
Module: trig_info_recorder

Interface
REQ-001 Parameter NUM_L4, default `SCAL_NUM_L4 (5); number of L4 trigger sources.
REQ-002 Parameter OFFSET_BITS, default 9; width of the T1 offset field.
REQ-003 Parameter DEPTH_LOG2, default 4; buffer depth is 2**DEPTH_LOG2 entries.
REQ-004 One clock; reset is asynchronous and active-low (ports clk_i, rst_n_i).
REQ-005 clk_i  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n_i  input  1  asynchronous active-low reset.
REQ-007 T1_i  input  1  single-cycle T1 pulse from the trigger processor.
REQ-008 l4_matched_i  input  NUM_L4  L4 sources contributing to this T1; valid when T1_i=1.
REQ-009 T1_offset_i  input  OFFSET_BITS  T1 offset; valid when T1_i=1.
REQ-010 disable_i  input  1  1 = ignore T1_i.
REQ-011 clear_i  input  1  single-cycle: flush buffer, zero event number, drop count, overflow flag.
REQ-012 info_o  output  16+NUM_L4+OFFSET_BITS  head entry {event_num[15:0], l4_matched, offset}.
REQ-013 time_o  output  32  head entry timestamp.
REQ-014 info_valid_o  output  1  head entry present.
REQ-015 info_ready_i  input  1  consumer accepts head entry.
REQ-016 overflow_o  output  1  sticky: at least one T1 dropped since last clear/reset.
REQ-017 drop_count_o  output  8  dropped-T1 count, saturating at 255.

Function
REQ-018 32-bit free-running timestamp counter shall increment every cycle and wrap 0xFFFFFFFF->0.
REQ-019 An eligible T1 is T1_i=1 with disable_i=0 and clear_i=0.
REQ-020 Each eligible T1 shall increment the 16-bit event counter (wraps 0xFFFF->0), whether stored or dropped; dropped events therefore appear as gaps.
REQ-021 An eligible T1 on edge k shall store {current event number, l4_matched_i, T1_offset_i} plus the edge-k timestamp value; info_valid_o high after edge k (1-cycle latency).
REQ-022 Buffer shall be FIFO, first-word-fall-through: info_o/time_o show the oldest entry whenever info_valid_o=1.
REQ-023 Handshake: entry popped on an edge where info_valid_o=1 and info_ready_i=1; info_ready_i ignored when info_valid_o=0.
REQ-024 info_o/time_o shall stay stable while info_valid_o=1 and info_ready_i=0.
REQ-025 Empty buffer: no bypass; T1 and info_ready_i on the same edge shall store the entry, and info_valid_o rises after that edge.
REQ-026 Full buffer with no pop: eligible T1 shall be dropped, overflow_o set, drop_count_o incremented (saturating).
REQ-027 Full buffer with pop on the same edge: T1 shall be stored; no drop.
REQ-028 clear_i shall have priority over T1_i and pop: buffer emptied, event counter=0, drop_count_o=0, overflow_o=0; timestamp unaffected.
REQ-029 disable_i=1 shall not affect draining of stored entries.

Reset
REQ-030 rst_n_i low shall immediately force: buffer empty, info_valid_o=0, event counter=0, timestamp=0, overflow_o=0, drop_count_o=0.
REQ-031 Reset mid-operation discards all stored entries; info_o/time_o are don't-care while info_valid_o=0.

Structure
REQ-032 NUM_L4 default and entry field widths shall come from the shared trigger_defs.vh.
REQ-033 Storage shall be one sub-module, trig_info_fifo: parameterised synchronous FWFT FIFO with flush input, full/empty outputs.
REQ-034 Counters, drop/overflow logic and entry packing shall live in trig_info_recorder.

Verification
REQ-035 Single T1 (l4_matched=5'b00011, offset=53) at timestamp T -> one entry {0, 00011, 53}, time_o=T, info_valid_o high next cycle.
REQ-036 Four T1s with info_ready_i=0, then ready=1 -> four entries in order, event numbers 0-3, timestamps strictly increasing.
REQ-037 Depth 16, ready=0, 20 T1s -> 16 stored (event 0-15), overflow_o=1, drop_count_o=4; next stored event number is 20.
REQ-038 Full buffer, T1 and pop on the same edge -> no drop; count stays 16; last entry holds the new event.
REQ-039 disable_i=1 during 3 T1s -> nothing stored, event counter unchanged; clear_i coincident with T1 -> empty buffer, counters 0.
REQ-040 rst_n_i asserted mid-burst -> info_valid_o=0 immediately; first post-reset T1 gives event 0.

Source files
------------

// File: rtl/trig_info_recorder_pkg.sv
// Shared widths and defaults for the T1 info recorder: event/timestamp/drop
// field sizes, the default L4 source count and the saturating drop increment.
package trig_info_recorder_pkg;

    localparam int SCAL_NUM_L4 = 5;
    localparam int EVT_BITS    = 16;
    localparam int TS_BITS     = 32;
    localparam int DROP_BITS   = 8;

    localparam logic [DROP_BITS-1:0] DROP_MAX = '1;

    function automatic logic [DROP_BITS-1:0] sat_inc(input logic [DROP_BITS-1:0] v);
        return (v == DROP_MAX) ? v : v + DROP_BITS'(1);
    endfunction

endpackage

// File: rtl/trig_info_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a write is visible at head one cycle later.
// Push is refused only when full without a same-cycle pop; pop is ignored when empty; flush wins over both.
module trig_info_fifo #(
    parameter int WIDTH      = 62,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign head_dat_o = mem_q[rd_ptr_q];

    // A pop frees the slot the same edge, so a full FIFO can still accept a push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(1);
                2'b01:   cnt_d = cnt_q - (DEPTH_LOG2 + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/trig_info_recorder.sv
// Records {event number, L4 match, offset, timestamp} per eligible T1 into a FWFT buffer; 1-cycle latency.
// Valid/ready drain; when the buffer is full and not popping, T1s are dropped and counted (sticky overflow).
module trig_info_recorder
    import trig_info_recorder_pkg::*;
#(
    parameter int NUM_L4      = SCAL_NUM_L4,
    parameter int OFFSET_BITS = 9,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  T1_i,
    input  logic [NUM_L4-1:0]                     l4_matched_i,
    input  logic [OFFSET_BITS-1:0]                T1_offset_i,
    input  logic                                  disable_i,
    input  logic                                  clear_i,
    output logic [EVT_BITS+NUM_L4+OFFSET_BITS-1:0] info_o,
    output logic [TS_BITS-1:0]                    time_o,
    output logic                                  info_valid_o,
    input  logic                                  info_ready_i,
    output logic                                  overflow_o,
    output logic [DROP_BITS-1:0]                  drop_count_o
);

    localparam int INFO_W  = EVT_BITS + NUM_L4 + OFFSET_BITS;
    localparam int ENTRY_W = INFO_W + TS_BITS;

    logic [TS_BITS-1:0]   ts_q, ts_d;
    logic [EVT_BITS-1:0]  evt_q, evt_d;
    logic [DROP_BITS-1:0] drop_q, drop_d;
    logic                 ovf_q, ovf_d;

    logic               eligible, pop, push, drop;
    logic               fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] push_dat, head_dat;

    assign eligible = T1_i & ~disable_i & ~clear_i;
    assign pop      = info_valid_o & info_ready_i & ~clear_i;
    assign drop     = eligible & fifo_full & ~pop;
    assign push     = eligible & ~drop;

    // The timestamp captured is the counter value sampled on the T1 edge itself.
    assign push_dat = {evt_q, l4_matched_i, T1_offset_i, ts_q};

    always_comb begin
        ts_d   = ts_q + TS_BITS'(1);
        evt_d  = evt_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            evt_d  = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else if (eligible) begin
            evt_d = evt_q + EVT_BITS'(1);
            if (drop) begin
                drop_d = sat_inc(drop_q);
                ovf_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ts_q   <= '0;
            evt_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            evt_q  <= evt_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    trig_info_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (clear_i),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign info_valid_o = ~fifo_empty;
    assign info_o       = head_dat[ENTRY_W-1:TS_BITS];
    assign time_o       = head_dat[TS_BITS-1:0];
    assign overflow_o   = ovf_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_trig_info_recorder.sv
// Scoreboard bench for trig_info_recorder: every driven cycle updates a reference model
// and the DUT head/valid/overflow/drop outputs are compared against it.
module tb_trig_info_recorder;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [29:0] info;
        logic [31:0] tm;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        T1_i = 1'b0;
    logic [4:0]  l4_matched_i = '0;
    logic [8:0]  T1_offset_i = '0;
    logic        disable_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [29:0] info_o;
    logic [31:0] time_o;
    logic        info_valid_o;
    logic        info_ready_i = 1'b0;
    logic        overflow_o;
    logic [7:0]  drop_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        sb[$];
    exp_t        last_pop;
    logic [15:0] m_evt  = '0;
    logic [7:0]  m_drop = '0;
    logic        m_ovf  = 1'b0;
    logic [31:0] m_ts;

    trig_info_recorder dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .T1_i         (T1_i),
        .l4_matched_i (l4_matched_i),
        .T1_offset_i  (T1_offset_i),
        .disable_i    (disable_i),
        .clear_i      (clear_i),
        .info_o       (info_o),
        .time_o       (time_o),
        .info_valid_o (info_valid_o),
        .info_ready_i (info_ready_i),
        .overflow_o   (overflow_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) m_ts <= '0;
        else          m_ts <= m_ts + 32'd1;
    end

    // One clock of stimulus: check current outputs, advance the model, then take the edge.
    task automatic cyc(input logic t1, input logic [4:0] l4, input logic [8:0] off,
                       input logic dis, input logic clr, input logic rdy);
        logic mpop;
        exp_t e;
        T1_i = t1; l4_matched_i = l4; T1_offset_i = off;
        disable_i = dis; clear_i = clr; info_ready_i = rdy;

        n_tests++;
        if (info_valid_o !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL valid @%0t: got %0b want %0b", $time, info_valid_o, sb.size() != 0);
        end
        if (sb.size() != 0) begin
            n_tests++;
            if ({info_o, time_o} !== sb[0]) begin
                n_fail++;
                $display("FAIL head @%0t: got info=%h time=%h want info=%h time=%h",
                         $time, info_o, time_o, sb[0].info, sb[0].tm);
            end
        end
        n_tests++;
        if (overflow_o !== m_ovf) begin
            n_fail++;
            $display("FAIL overflow @%0t: got %0b want %0b", $time, overflow_o, m_ovf);
        end
        n_tests++;
        if (drop_count_o !== m_drop) begin
            n_fail++;
            $display("FAIL drop_count @%0t: got %0d want %0d", $time, drop_count_o, m_drop);
        end

        mpop = rdy && (sb.size() != 0) && !clr;
        if (clr) begin
            sb.delete();
            m_evt  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
        end else begin
            if (mpop) last_pop = sb.pop_front();
            if (t1 && !dis) begin
                if (sb.size() == DEPTH) begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'd255) m_drop = m_drop + 8'd1;
                end else begin
                    e.info = {m_evt, l4, off};
                    e.tm   = m_ts;
                    sb.push_back(e);
                end
                m_evt = m_evt + 16'd1;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            cyc(1'b0, 5'd0, 9'd0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d entries left want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (info_valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_count_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%0b ovf=%0b drop=%0d want 0 0 0",
                     info_valid_o, overflow_o, drop_count_o);
        end
    endtask

    task automatic test_single();
        logic [31:0] t;
        t = m_ts;
        cyc(1'b1, 5'b00011, 9'd53, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (info_valid_o !== 1'b1 || info_o !== {16'd0, 5'b00011, 9'd53} || time_o !== t) begin
            n_fail++;
            $display("FAIL single: got v=%0b info=%h time=%h want v=1 info=%h time=%h",
                     info_valid_o, info_o, time_o, {16'd0, 5'b00011, 9'd53}, t);
        end
        drain(8);
    endtask

    task automatic test_four_in_order();
        logic [31:0] prev;
        cyc(1'b0, 5'd0, 9'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 5'(i + 1), 9'(i * 7), 1'b0, 1'b0, 1'b0);
        prev = 32'd0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 5'd0, 9'd0, 1'b0, 1'b0, 1'b1);
            n_tests++;
            if (last_pop.info[29:14] !== 16'(i) || (i > 0 && last_pop.tm <= prev)) begin
                n_fail++;
                $display("FAIL four_order[%0d]: got evt=%0d time=%0d want evt=%0d time>%0d",
                         i, last_pop.info[29:14], last_pop.tm, i, prev);
            end
            prev = last_pop.tm;
        end
        drain(4);
    endtask

    task automatic test_overflow_and_full_pop();
        cyc(1'b0, 5'd0, 9'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 5'(i), 9'(i), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (overflow_o !== 1'b1 || drop_count_o !== 8'd4) begin
            n_fail++;
            $display("FAIL overflow20: got ovf=%0b drop=%0d want 1 4", overflow_o, drop_count_o);
        end
        // Full buffer with a simultaneous pop must still accept the new T1.
        cyc(1'b1, 5'b10101, 9'd300, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (drop_count_o !== 8'd4 || sb.size() != DEPTH) begin
            n_fail++;
            $display("FAIL full_pop: got drop=%0d model_cnt=%0d want 4 16", drop_count_o, sb.size());
        end
        drain(20);
        n_tests++;
        if (last_pop.info !== {16'd20, 5'b10101, 9'd300}) begin
            n_fail++;
            $display("FAIL full_pop_last: got %h want %h", last_pop.info, {16'd20, 5'b10101, 9'd300});
        end
    endtask

    task automatic test_drop_saturation();
        cyc(1'b0, 5'd0, 9'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 270; i++)
            cyc(1'b1, 5'd1, 9'd1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (drop_count_o !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_sat: got %0d want 255", drop_count_o);
        end
        drain(20);
    endtask

    task automatic test_disable_clear();
        logic [15:0] evt_before;
        cyc(1'b0, 5'd0, 9'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 5'd2, 9'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd3, 9'd3, 1'b0, 1'b0, 1'b0);
        evt_before = m_evt;
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 5'd9, 9'd9, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (info_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_drain: got valid=%0b want 0", info_valid_o);
        end
        cyc(1'b1, 5'd4, 9'd4, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (info_o[29:14] !== evt_before) begin
            n_fail++;
            $display("FAIL disable_evt: got %0d want %0d", info_o[29:14], evt_before);
        end
        for (int i = 0; i < DEPTH + 2; i++)
            cyc(1'b1, 5'd5, 9'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd6, 9'd6, 1'b0, 1'b1, 1'b1);
        n_tests++;
        if (info_valid_o !== 1'b0 || overflow_o !== 1'b0 || drop_count_o !== 8'd0) begin
            n_fail++;
            $display("FAIL clear: got v=%0b ovf=%0b drop=%0d want 0 0 0",
                     info_valid_o, overflow_o, drop_count_o);
        end
        cyc(1'b1, 5'd7, 9'd7, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (info_o[29:14] !== 16'd0) begin
            n_fail++;
            $display("FAIL clear_evt: got %0d want 0", info_o[29:14]);
        end
        drain(4);
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 5'd8, 9'(i), 1'b0, 1'b0, 1'b0);
        rst_n_i = 1'b0;
        #1;
        n_tests++;
        if (info_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%0b want 0", info_valid_o);
        end
        sb.delete();
        m_evt = '0; m_drop = '0; m_ovf = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        cyc(1'b1, 5'd1, 9'd11, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (info_o[29:14] !== 16'd0 || info_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_evt: got evt=%0d v=%0b want 0 1", info_o[29:14], info_valid_o);
        end
        drain(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 500; i++)
            cyc(1'($urandom_range(0, 1)), 5'($urandom), 9'($urandom),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0),
                1'($urandom_range(0, 2) == 0));
        drain(20);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        test_reset();
        test_single();
        test_four_in_order();
        test_overflow_and_full_pop();
        test_drop_saturation();
        test_disable_clear();
        test_reset_midburst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
